uart_boot_loader: RTL and testbench

Parametrised UART boot programmer: next generation of the SoC's program-load path. It receives a framed image (length header, data words, checksum) over 8N1 UART, writes words into instruction memory, and holds the core in reset until a load completes with a valid checksum. Data, address and length widths are parametrised. It adds integrity checking, framing-error detection, abort handling and status outputs that the current programmer lacks.

---
 rtl/uart_boot_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot programmer: receives a length-prefixed, checksummed image over 8N1 UART,
// writes it to instruction memory word by word, and holds the core in reset until it loads cleanly.
module uart_boot_loader #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4),
   parameter int                CPB_W     = 16,
   parameter int                LEN_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_i,
   input  logic              rx_i,
   input  logic [CPB_W-1:0]  clks_per_bit,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              core_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int         BPW      = DATA_W / 8;
   localparam int         HB       = LEN_W / 8;
   localparam logic [7:0] BPW_LAST = 8'(BPW - 1);
   localparam logic [7:0] HB_LAST  = 8'(HB - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

   logic [1:0] prog_sync, rx_sync;
   logic       prog_s, rx_s, rx_prev;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prog_sync <= 2'b00;
         rx_sync   <= 2'b11;
         rx_prev   <= 1'b1;
      end else begin
         prog_sync <= {prog_sync[0], prog_i};
         rx_sync   <= {rx_sync[0], rx_i};
         rx_prev   <= rx_s;
      end
   end

   assign prog_s = prog_sync[1];
   assign rx_s   = rx_sync[1];

   // Bit timing: rates faster than 4 clocks per bit leave no room for a half-bit sample.
   logic [CPB_W-1:0] cpb_eff, cpb_m1, half_m1;
   assign cpb_eff = (clks_per_bit < CPB_W'(4)) ? CPB_W'(4) : clks_per_bit;
   assign cpb_m1  = cpb_eff - 1'b1;
   assign half_m1 = (cpb_eff >> 1) - 1'b1;

   rx_state_t        rx_state, rx_state_n;
   logic [CPB_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       rx_byte, rx_byte_n;
   logic             byte_valid, byte_valid_n;
   logic             frame_err, frame_err_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_state   <= rx_state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         rx_byte    <= rx_byte_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   // NOTE: every value written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      rx_state_n   = rx_state;
      cnt_n        = cnt;
      bit_cnt_n    = bit_cnt;
      rx_byte_n    = rx_byte;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      unique case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_state_n = RX_START;
               cnt_n      = '0;
            end
         end
         RX_START: begin
            if (cnt == half_m1) begin
               cnt_n      = '0;
               bit_cnt_n  = '0;
               rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == cpb_m1) begin
               cnt_n     = '0;
               rx_byte_n = {rx_s, rx_byte[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) rx_state_n = RX_STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == cpb_m1) begin
               rx_state_n   = RX_IDLE;
               byte_valid_n = rx_s;
               frame_err_n  = !rx_s;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   state_t            state, state_n;
   logic [LEN_W-1:0]  len_q, len_n, idx, idx_n, len_shift;
   logic [DATA_W-1:0] word_q, word_n, word_shift, wdata_n;
   logic [ADDR_W-1:0] next_addr, next_addr_n, addr_n;
   logic [7:0]        bcnt, bcnt_n, sum, sum_n, sum_add;
   logic              we_n, done_n, err_n, core_rst_n, abort;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         len_q      <= '0;
         idx        <= '0;
         word_q     <= '0;
         next_addr  <= '0;
         bcnt       <= '0;
         sum        <= '0;
         we_o       <= 1'b0;
         addr_o     <= '0;
         wdata_o    <= '0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         core_rst_o <= 1'b1;
      end else begin
         state      <= state_n;
         len_q      <= len_n;
         idx        <= idx_n;
         word_q     <= word_n;
         next_addr  <= next_addr_n;
         bcnt       <= bcnt_n;
         sum        <= sum_n;
         we_o       <= we_n;
         addr_o     <= addr_n;
         wdata_o    <= wdata_n;
         done_o     <= done_n;
         err_o      <= err_n;
         core_rst_o <= core_rst_n;
      end
   end

   // Little-endian assembly: each new byte enters at the top and earlier bytes shift down.
   assign len_shift  = (len_q >> 8) | (LEN_W'(rx_byte) << (LEN_W - 8));
   assign word_shift = (word_q >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
   assign sum_add    = sum + rx_byte;
   assign abort      = !prog_s || frame_err;

   always_comb begin
      state_n     = state;
      len_n       = len_q;
      idx_n       = idx;
      word_n      = word_q;
      next_addr_n = next_addr;
      bcnt_n      = bcnt;
      sum_n       = sum;
      we_n        = 1'b0;
      addr_n      = addr_o;
      wdata_n     = wdata_o;
      done_n      = done_o;
      err_n       = err_o;
      unique case (state)
         S_IDLE: begin
            if (prog_s) begin
               state_n     = S_LEN;
               done_n      = 1'b0;
               err_n       = 1'b0;
               len_n       = '0;
               idx_n       = '0;
               word_n      = '0;
               bcnt_n      = '0;
               sum_n       = '0;
               next_addr_n = BASE_ADDR;
            end
         end
         S_LEN: begin
            if (abort) begin
               state_n = S_ERR;
            end else if (byte_valid) begin
               len_n  = len_shift;
               sum_n  = sum_add;
               bcnt_n = bcnt + 8'd1;
               if (bcnt == HB_LAST) begin
                  bcnt_n  = '0;
                  state_n = (len_shift == '0) ? S_CSUM : S_DATA;
               end
            end
         end
         S_DATA: begin
            // The last write pulses while still in DATA; the move to CSUM follows one cycle later.
            if (abort) begin
               state_n = S_ERR;
            end else if (idx == len_q) begin
               state_n = S_CSUM;
            end else if (byte_valid) begin
               word_n = word_shift;
               sum_n  = sum_add;
               bcnt_n = bcnt + 8'd1;
               if (bcnt == BPW_LAST) begin
                  bcnt_n      = '0;
                  we_n        = 1'b1;
                  addr_n      = next_addr;
                  wdata_n     = word_shift;
                  next_addr_n = next_addr + ADDR_STEP;
                  idx_n       = idx + 1'b1;
               end
            end
         end
         S_CSUM: begin
            if (abort) begin
               state_n = S_ERR;
            end else if (byte_valid) begin
               sum_n   = sum_add;
               state_n = (sum_add == 8'h00) ? S_DONE : S_ERR;
            end
         end
         S_DONE:  if (!prog_s) state_n = S_IDLE;
         S_ERR:   if (!prog_s) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (state_n == S_DONE) done_n = 1'b1;
      if (state_n == S_ERR)  err_n  = 1'b1;
      core_rst_n = state_n inside {S_LEN, S_DATA, S_CSUM, S_ERR};
   end

   assign busy_o = state inside {S_LEN, S_DATA, S_CSUM};

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboarded bench for uart_boot_loader: directed UART frames in, expected memory writes
// queued at issue time and matched by an independent write monitor.
`timescale 1ns/1ps
module tb_uart_boot_loader;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int CPB_W  = 16;
   localparam int LEN_W  = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              prog_i;
   logic              rx_i;
   logic [CPB_W-1:0]  clks_per_bit;
   logic              we_o;
   logic [ADDR_W-1:0] addr_o;
   logic [DATA_W-1:0] wdata_o;
   logic              core_rst_o, busy_o, done_o, err_o;

   uart_boot_loader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR('0), .ADDR_STEP(32'd4),
      .CPB_W(CPB_W), .LEN_W(LEN_W)
   ) dut (
      .clock(clock), .reset(reset), .prog_i(prog_i), .rx_i(rx_i),
      .clks_per_bit(clks_per_bit), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
      .core_rst_o(core_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         checks = 0;
   int         fails  = 0;
   int         bit_period = 16;
   logic [7:0] stream [0:10] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46};

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued write.
   always @(negedge clock) begin : monitor
      wr_t e;
      if (!reset && we_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write queued", addr_o, wdata_o);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 64'(addr_o), 64'(e.addr));
            check("write_data", 64'(wdata_o), 64'(e.data));
            check("write_busy", 64'(busy_o), 64'd1);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx_i = 1'b0;
      cycles(bit_period);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         cycles(bit_period);
      end
      rx_i = stop;
      cycles(bit_period);
      rx_i = 1'b1;
      cycles(3);
   endtask

   task automatic send_stream(input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(stream[i], 1'b1);
   endtask

   task automatic push_good(input int n);
      wr_t w;
      w.addr = 32'h0; w.data = 32'h1122_3344;
      exp_q.push_back(w);
      if (n > 1) begin
         w.addr = 32'h4; w.data = 32'hAABB_CCDD;
         exp_q.push_back(w);
      end
   endtask

   task automatic check_status(input string tag, input logic done, input logic err,
                               input logic crst, input logic busy);
      check({tag, "_done"},     64'(done_o),     64'(done));
      check({tag, "_err"},      64'(err_o),      64'(err));
      check({tag, "_core_rst"}, 64'(core_rst_o), 64'(crst));
      check({tag, "_busy"},     64'(busy_o),     64'(busy));
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},    64'(we_o),    64'd0);
      check({tag, "_addr"},  64'(addr_o),  64'd0);
      check({tag, "_wdata"}, 64'(wdata_o), 64'd0);
      check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded 2000000 ns without completing");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; prog_i = 1'b0; rx_i = 1'b1; clks_per_bit = 16'd16;
      cycles(3);
      check_reset_values("por");
      reset = 1'b0;
      cycles(4);
      check("idle_core_rst", 64'(core_rst_o), 64'd0);

      // Good two-word load.
      push_good(2);
      prog_i = 1'b1; cycles(4);
      check_status("good_start", 1'b0, 1'b0, 1'b1, 1'b1);
      send_stream(0, 10); cycles(4);
      check_status("good_end", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("good");
      prog_i = 1'b0; cycles(4);
      check("good_done_held", 64'(done_o), 64'd1);

      // Bad checksum: both writes still land, then error.
      stream[10] = 8'h47;
      push_good(2);
      prog_i = 1'b1; cycles(4);
      check("bad_done_cleared", 64'(done_o), 64'd0);
      send_stream(0, 10); cycles(4);
      check_status("bad_end", 1'b0, 1'b1, 1'b1, 1'b0);
      check_drained("bad");
      prog_i = 1'b0; cycles(4);
      check_status("bad_released", 1'b0, 1'b1, 1'b0, 1'b0);
      stream[10] = 8'h46;

      // Framing error on the 4th byte; later bytes in ERR are ignored.
      prog_i = 1'b1; cycles(4);
      check("frame_err_cleared", 64'(err_o), 64'd0);
      send_stream(0, 2);
      send_byte(stream[3], 1'b0); cycles(4);
      check_status("frame_end", 1'b0, 1'b1, 1'b1, 1'b0);
      send_stream(4, 10); cycles(4);
      check_drained("frame");
      prog_i = 1'b0; cycles(4);

      // Abort after 5 bytes, then a zero-length image.
      prog_i = 1'b1; cycles(4);
      send_stream(0, 4);
      prog_i = 1'b0; cycles(6);
      check_status("abort_end", 1'b0, 1'b1, 1'b0, 1'b0);
      check_drained("abort");
      prog_i = 1'b1; cycles(4);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
      cycles(4);
      check_status("zero_end", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("zero");
      prog_i = 1'b0; cycles(4);

      // A 5-cycle low glitch must not produce a byte.
      prog_i = 1'b1; cycles(4);
      rx_i = 1'b0; cycles(5); rx_i = 1'b1; cycles(40);
      push_good(2);
      send_stream(0, 10); cycles(4);
      check_status("glitch_end", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("glitch");
      prog_i = 1'b0; cycles(4);

      // clks_per_bit = 2 runs at the 4-clock floor.
      clks_per_bit = 16'd2; bit_period = 4;
      push_good(2);
      prog_i = 1'b1; cycles(4);
      send_stream(0, 10); cycles(4);
      check_status("clamp_end", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("clamp");
      prog_i = 1'b0; cycles(4);
      clks_per_bit = 16'd16; bit_period = 16;

      // Reset in the middle of the second word, then a fresh load from address 0.
      push_good(1);
      prog_i = 1'b1; cycles(4);
      send_stream(0, 6);
      reset = 1'b1; prog_i = 1'b0;
      cycles(1);
      check_reset_values("midreset");
      cycles(2);
      reset = 1'b0; cycles(4);
      check_drained("midreset");
      push_good(2);
      prog_i = 1'b1; cycles(4);
      send_stream(0, 10); cycles(4);
      check_status("reload_end", 1'b1, 1'b0, 1'b0, 1'b0);
      check_drained("reload");
      prog_i = 1'b0; cycles(4);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
